mem_burst_reader: RTL and testbench
===================================

MEM_BURST_READER -- requirements
Module: mem_burst_reader

Interface
REQ-001 Parameter: ADDR_STEP, default 16, address increment per 144-bit word.
REQ-002 Parameter: MAX_OUTSTANDING, default 8, maximum accepted-but-unreturned read commands (range 1..15).
REQ-003 Parameter: LEN_WIDTH, default 16, width of num_words.
REQ-004 One clock; reset is asynchronous and active-high; ports Mem_Clk and Mem_Rst.
REQ-005 Mem_Clk  in  1  block clock, same domain as the memory-side command/read port.
REQ-006 Mem_Rst  in  1  asynchronous active-high reset.
REQ-007 start  in  1  begin burst; sampled only in IDLE.
REQ-008 base_addr  in  32  address of word 0; sampled with start.
REQ-009 num_words  in  LEN_WIDTH  words to read; sampled with start.
REQ-010 busy  out  1  high in any state other than IDLE.
REQ-011 done  out  1  one-cycle pulse on burst completion.
REQ-012 tag_err  out  1  sticky read-tag mismatch flag.
REQ-013 Mem_Cmd_Address  out  32  read address.
REQ-014 Mem_Cmd_RNW  out  1  constant 1 (read).
REQ-015 Mem_Cmd_Valid  out  1  command request.
REQ-016 Mem_Cmd_Tag  out  32  word index, zero-extended.
REQ-017 Mem_Cmd_Ack  in  1  command accepted this cycle.
REQ-018 Mem_Rd_Dout  in  144  returned read data.
REQ-019 Mem_Rd_Tag  in  32  tag of the returned data.
REQ-020 Mem_Rd_Valid  in  1  read data present.
REQ-021 Mem_Rd_Ack  out  1  read data consumed this cycle.
REQ-022 dout  out  144  data to the downstream consumer.
REQ-023 dout_valid  out  1  dout valid.
REQ-024 dout_ready  in  1  downstream accepts dout.

Function
REQ-025 States: IDLE, ISSUE, DRAIN, DONE.
REQ-026 IDLE, start=1, num_words>0 -> latch base_addr and num_words, clear issue/return counters and tag_err, go to ISSUE.
REQ-027 IDLE, start=1, num_words=0 -> DONE; no command issued; tag_err cleared.
REQ-028 ISSUE: Mem_Cmd_Valid=1 while issued<num_words and outstanding<MAX_OUTSTANDING; otherwise 0.
REQ-029 Command accepted on a cycle with Mem_Cmd_Valid=1 and Mem_Cmd_Ack=1; Address and Tag held stable until acceptance.
REQ-030 Mem_Cmd_Address = latched base + issued*ADDR_STEP, modulo 2^32 (wraps silently).
REQ-031 Mem_Cmd_Tag = issued index, zero-extended to 32 bits.
REQ-032 Read accepted on a cycle with Mem_Rd_Valid=1 and Mem_Rd_Ack=1.
REQ-033 outstanding +1 on command accept, -1 on read accept, unchanged when both occur in the same cycle.
REQ-034 ISSUE -> DRAIN on the cycle the last command is accepted.
REQ-035 DRAIN -> DONE on the cycle the read with returned count num_words-1 is accepted.
REQ-036 DONE: done=1 for exactly one cycle, then IDLE; start is ignored in DONE.
REQ-037 In ISSUE and DRAIN: dout=Mem_Rd_Dout, dout_valid=Mem_Rd_Valid, Mem_Rd_Ack=dout_ready (combinational, zero latency).
REQ-038 In ISSUE and DRAIN, on each read accept: if Mem_Rd_Tag differs from the returned count, set tag_err; data is still forwarded and counted.
REQ-039 In IDLE and DONE: dout_valid=0, Mem_Rd_Ack=1 (stray data dropped); a stray Mem_Rd_Valid sets tag_err.
REQ-040 tag_err cleared only by reset or an accepted start.
REQ-041 Backpressure: with dout_ready=0, no reads are accepted, so outstanding saturates at MAX_OUTSTANDING and issue stalls.

Reset
REQ-042 While Mem_Rst=1, asynchronously: state=IDLE, all counters=0, and busy, done, tag_err, Mem_Cmd_Valid, Mem_Cmd_Address, Mem_Cmd_Tag=0.
REQ-043 Mem_Cmd_RNW=1 at all times, including reset.
REQ-044 Reset mid-burst abandons the burst with no done pulse; after reset, late returns follow REQ-039.

Verification
REQ-045 base=0x100, num_words=4, Ack always 1, in-order tags -> addresses 0x100/0x110/0x120/0x130, tags 0..3, four dout beats, one done pulse, tag_err=0.
REQ-046 num_words=20, dout_ready=0 for 50 cycles -> exactly 8 commands accepted, then Valid held 0 until dout_ready=1; all 20 words delivered.
REQ-047 base=0xFFFFFFF0, num_words=3 -> addresses 0xFFFFFFF0, 0x00000000, 0x00000010.
REQ-048 num_words=0 -> done pulses on the cycle after start, Mem_Cmd_Valid never asserted, busy high for one cycle.
REQ-049 Second return carries tag 5 instead of 1 -> tag_err=1 and held through done; the next start clears it.
REQ-050 Mem_Rst pulsed after 2 of 6 commands -> all outputs 0 immediately, no done pulse, a late Mem_Rd_Valid is acked and sets tag_err.

Source files
------------

// File: rtl/mem_burst_reader.sv
// Burst reader: issues up to num_words tagged read commands from a base address,
// keeps at most MAX_OUTSTANDING in flight, and forwards returned data downstream.
module mem_burst_reader #(
  parameter int ADDR_STEP       = 16,
  parameter int MAX_OUTSTANDING = 8,
  parameter int LEN_WIDTH       = 16
) (
  input  logic                 Mem_Clk,
  input  logic                 Mem_Rst,
  input  logic                 start,
  input  logic [31:0]          base_addr,
  input  logic [LEN_WIDTH-1:0] num_words,
  output logic                 busy,
  output logic                 done,
  output logic                 tag_err,
  output logic [31:0]          Mem_Cmd_Address,
  output logic                 Mem_Cmd_RNW,
  output logic                 Mem_Cmd_Valid,
  output logic [31:0]          Mem_Cmd_Tag,
  input  logic                 Mem_Cmd_Ack,
  input  logic [143:0]         Mem_Rd_Dout,
  input  logic [31:0]          Mem_Rd_Tag,
  input  logic                 Mem_Rd_Valid,
  output logic                 Mem_Rd_Ack,
  output logic [143:0]         dout,
  output logic                 dout_valid,
  input  logic                 dout_ready
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  localparam logic [3:0]           MAX_OUT = 4'(MAX_OUTSTANDING);
  localparam logic [31:0]          STEP    = 32'(ADDR_STEP);
  localparam logic [LEN_WIDTH-1:0] ONE     = LEN_WIDTH'(1);

  state_t               state, state_next;
  logic [31:0]          cmd_addr;
  logic [LEN_WIDTH-1:0] len, issued, returned;
  logic [3:0]           outstanding;
  logic                 tag_err_q;

  logic active, start_ok, cmd_acc, rd_acc, rd_acc_active;
  logic last_cmd, last_rd, tag_bad;

  assign active        = (state == ISSUE) || (state == DRAIN);
  assign start_ok      = (state == IDLE) && start;
  assign cmd_acc       = Mem_Cmd_Valid && Mem_Cmd_Ack;
  assign rd_acc        = Mem_Rd_Valid && Mem_Rd_Ack;
  assign rd_acc_active = rd_acc && active;
  assign last_cmd      = cmd_acc && (issued == len - ONE);
  assign last_rd       = rd_acc_active && (returned == len - ONE);
  // Outside a burst every read is unexpected, so any valid beat is an error.
  assign tag_bad       = active ? (rd_acc && (Mem_Rd_Tag != 32'(returned))) : Mem_Rd_Valid;

  assign Mem_Cmd_RNW     = 1'b1;
  assign Mem_Cmd_Address = cmd_addr;
  assign Mem_Cmd_Tag     = 32'(issued);
  assign tag_err         = tag_err_q;

  // NOTE: state register alone is clocked; all decoding lives in the always_comb below.
  always_ff @(posedge Mem_Clk or posedge Mem_Rst) begin
    if (Mem_Rst) state <= IDLE;
    else         state <= state_next;
  end

  // NOTE: every output gets a default before the case, so no path leaves one unassigned (no latches).
  always_comb begin
    state_next    = state;
    busy          = (state != IDLE);
    done          = 1'b0;
    Mem_Cmd_Valid = 1'b0;
    dout          = '0;
    dout_valid    = 1'b0;
    Mem_Rd_Ack    = 1'b1;
    case (state)
      IDLE: begin
        if (start) state_next = (num_words == '0) ? DONE : ISSUE;
      end
      ISSUE: begin
        Mem_Cmd_Valid = (issued < len) && (outstanding < MAX_OUT);
        dout          = Mem_Rd_Dout;
        dout_valid    = Mem_Rd_Valid;
        Mem_Rd_Ack    = dout_ready;
        if (last_cmd) state_next = last_rd ? DONE : DRAIN;
      end
      DRAIN: begin
        dout       = Mem_Rd_Dout;
        dout_valid = Mem_Rd_Valid;
        Mem_Rd_Ack = dout_ready;
        if (last_rd) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge Mem_Clk or posedge Mem_Rst) begin
    if (Mem_Rst) begin
      cmd_addr    <= '0;
      len         <= '0;
      issued      <= '0;
      returned    <= '0;
      outstanding <= '0;
      tag_err_q   <= 1'b0;
    end else if (start_ok) begin
      cmd_addr    <= base_addr;
      len         <= num_words;
      issued      <= '0;
      returned    <= '0;
      outstanding <= '0;
      tag_err_q   <= 1'b0;
    end else begin
      if (cmd_acc) begin
        issued   <= issued + ONE;
        cmd_addr <= cmd_addr + STEP;
      end
      if (rd_acc_active) returned <= returned + ONE;
      // A return with nothing in flight is a protocol error; don't let the count wrap.
      if (cmd_acc && !(rd_acc_active && outstanding != '0))
        outstanding <= outstanding + 4'd1;
      else if (!cmd_acc && rd_acc_active && outstanding != '0)
        outstanding <= outstanding - 4'd1;
      if (tag_bad) tag_err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_burst_reader.sv
// Self-checking bench for mem_burst_reader: an in-order memory model plus a
// scoreboard of expected command addresses/tags and downstream data beats.
module tb_mem_burst_reader;

  logic         Mem_Clk = 1'b0;
  logic         Mem_Rst;
  logic         start;
  logic [31:0]  base_addr;
  logic [15:0]  num_words;
  logic         busy, done, tag_err;
  logic [31:0]  Mem_Cmd_Address, Mem_Cmd_Tag;
  logic         Mem_Cmd_RNW, Mem_Cmd_Valid, Mem_Cmd_Ack;
  logic [143:0] Mem_Rd_Dout;
  logic [31:0]  Mem_Rd_Tag;
  logic         Mem_Rd_Valid, Mem_Rd_Ack;
  logic [143:0] dout;
  logic         dout_valid, dout_ready;

  mem_burst_reader dut (
    .Mem_Clk(Mem_Clk), .Mem_Rst(Mem_Rst), .start(start), .base_addr(base_addr),
    .num_words(num_words), .busy(busy), .done(done), .tag_err(tag_err),
    .Mem_Cmd_Address(Mem_Cmd_Address), .Mem_Cmd_RNW(Mem_Cmd_RNW),
    .Mem_Cmd_Valid(Mem_Cmd_Valid), .Mem_Cmd_Tag(Mem_Cmd_Tag), .Mem_Cmd_Ack(Mem_Cmd_Ack),
    .Mem_Rd_Dout(Mem_Rd_Dout), .Mem_Rd_Tag(Mem_Rd_Tag), .Mem_Rd_Valid(Mem_Rd_Valid),
    .Mem_Rd_Ack(Mem_Rd_Ack), .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready)
  );

  always #5 Mem_Clk = ~Mem_Clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] tag;
  } cmd_t;

  cmd_t         mem_q[$];
  logic [31:0]  exp_addr_q[$];
  logic [31:0]  exp_tag_q[$];
  logic [143:0] exp_data_q[$];

  int n_tests = 0, n_fail = 0;
  int cmd_cnt, beat_cnt, done_cnt, valid_cnt, busy_cnt;
  logic tag_at_done;
  bit ack_rand = 0;
  int rd_pct = 100;
  int corrupt_tag = -1;

  task automatic check(input string name, input logic [143:0] got, input logic [143:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [143:0] data_of(input logic [31:0] a);
    return {a, ~a, a ^ 32'hA5A5_A5A5, a + 32'd1, 16'hBEEF};
  endfunction

  // Memory side of the cycle, applied at the falling edge.
  task automatic drive_inputs();
    Mem_Cmd_Ack = ack_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    if (mem_q.size() > 0 && int'($urandom_range(0, 99)) < rd_pct) begin
      Mem_Rd_Valid = 1'b1;
      Mem_Rd_Tag   = (int'(mem_q[0].tag) == corrupt_tag) ? 32'd5 : mem_q[0].tag;
      Mem_Rd_Dout  = data_of(mem_q[0].addr);
    end else begin
      Mem_Rd_Valid = 1'b0;
      Mem_Rd_Tag   = '0;
      Mem_Rd_Dout  = '0;
    end
  endtask

  // Observe the handshakes that will complete at the coming rising edge, then advance.
  task automatic tick();
    #1;
    if (Mem_Cmd_Valid && Mem_Cmd_Ack) begin
      cmd_cnt++;
      if (exp_addr_q.size() == 0) begin
        check("cmd_extra", 144'(Mem_Cmd_Address), 144'(32'hDEAD_0000));
      end else begin
        check("cmd_addr", 144'(Mem_Cmd_Address), 144'(exp_addr_q.pop_front()));
        check("cmd_tag", 144'(Mem_Cmd_Tag), 144'(exp_tag_q.pop_front()));
      end
      mem_q.push_back('{addr: Mem_Cmd_Address, tag: Mem_Cmd_Tag});
    end
    if (dout_valid && dout_ready) begin
      beat_cnt++;
      if (exp_data_q.size() == 0) check("dout_extra", dout, ~dout);
      else                        check("dout", dout, exp_data_q.pop_front());
    end
    if (Mem_Rd_Valid && Mem_Rd_Ack && mem_q.size() > 0) void'(mem_q.pop_front());
    if (done) tag_at_done = tag_err;
    done_cnt  += int'(done);
    valid_cnt += int'(Mem_Cmd_Valid);
    busy_cnt  += int'(busy);
    @(negedge Mem_Clk);
    drive_inputs();
  endtask

  task automatic do_start(input logic [31:0] base, input int n);
    cmd_cnt = 0; beat_cnt = 0; done_cnt = 0; valid_cnt = 0; busy_cnt = 0;
    exp_addr_q.delete(); exp_tag_q.delete(); exp_data_q.delete();
    for (int i = 0; i < n; i++) begin
      logic [31:0] a;
      a = base + 32'(i) * 32'd16;
      exp_addr_q.push_back(a);
      exp_tag_q.push_back(32'(i));
      exp_data_q.push_back(data_of(a));
    end
    start = 1'b1; base_addr = base; num_words = 16'(n);
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < budget && done_cnt == d0; i++) tick();
    if (done_cnt == d0) check("done_timeout", 144'(0), 144'(1));
  endtask

  initial begin
    Mem_Rst = 1'b1; start = 1'b0; base_addr = '0; num_words = '0; dout_ready = 1'b1;
    Mem_Cmd_Ack = 1'b0; Mem_Rd_Valid = 1'b0; Mem_Rd_Tag = '0; Mem_Rd_Dout = '0;
    tag_at_done = 1'b0;
    repeat (2) @(negedge Mem_Clk);
    check("rst_busy", 144'(busy), 144'(0));
    check("rst_done", 144'(done), 144'(0));
    check("rst_tag_err", 144'(tag_err), 144'(0));
    check("rst_cmd_valid", 144'(Mem_Cmd_Valid), 144'(0));
    check("rst_addr", 144'(Mem_Cmd_Address), 144'(0));
    check("rst_tag", 144'(Mem_Cmd_Tag), 144'(0));
    check("rst_rnw", 144'(Mem_Cmd_RNW), 144'(1));
    Mem_Rst = 1'b0;
    drive_inputs();

    // Basic in-order burst.
    do_start(32'h100, 4);
    wait_done(200);
    repeat (3) tick();
    check("b1_cmds", 144'(cmd_cnt), 144'(4));
    check("b1_beats", 144'(beat_cnt), 144'(4));
    check("b1_done_pulses", 144'(done_cnt), 144'(1));
    check("b1_tag_err", 144'(tag_err), 144'(0));

    // Downstream stall: issue must stop at the outstanding limit.
    dout_ready = 1'b0;
    do_start(32'h2000, 20);
    repeat (49) tick();
    check("bp_cmds", 144'(cmd_cnt), 144'(8));
    check("bp_valid_cycles", 144'(valid_cnt), 144'(8));
    check("bp_valid_now", 144'(Mem_Cmd_Valid), 144'(0));
    check("bp_busy", 144'(busy), 144'(1));
    dout_ready = 1'b1; rd_pct = 60;
    wait_done(2000);
    check("bp_cmds_all", 144'(cmd_cnt), 144'(20));
    check("bp_beats", 144'(beat_cnt), 144'(20));
    check("bp_tag_err", 144'(tag_err), 144'(0));

    // Address wrap with random command acceptance.
    ack_rand = 1;
    do_start(32'hFFFF_FFF0, 3);
    wait_done(500);
    check("wrap_beats", 144'(beat_cnt), 144'(3));
    ack_rand = 0; rd_pct = 100;

    // Zero-length burst.
    do_start(32'h300, 0);
    check("zero_done_next", 144'(done), 144'(1));
    repeat (3) tick();
    check("zero_done_pulses", 144'(done_cnt), 144'(1));
    check("zero_valid", 144'(valid_cnt), 144'(0));
    check("zero_busy_cycles", 144'(busy_cnt), 144'(1));

    // Corrupted tag on the second return; sticky until next start.
    corrupt_tag = 1;
    do_start(32'h400, 4);
    wait_done(200);
    check("terr_at_done", 144'(tag_at_done), 144'(1));
    check("terr_held", 144'(tag_err), 144'(1));
    check("terr_beats", 144'(beat_cnt), 144'(4));
    corrupt_tag = -1;
    do_start(32'h500, 2);
    check("terr_cleared", 144'(tag_err), 144'(0));
    wait_done(200);
    check("terr_clean", 144'(tag_err), 144'(0));

    // Reset mid-burst, then late returns arrive.
    rd_pct = 0;
    do_start(32'h600, 6);
    for (int i = 0; i < 20 && cmd_cnt < 2; i++) tick();
    check("mr_cmds", 144'(cmd_cnt), 144'(2));
    Mem_Rst = 1'b1;
    #1;
    check("mr_busy", 144'(busy), 144'(0));
    check("mr_cmd_valid", 144'(Mem_Cmd_Valid), 144'(0));
    check("mr_addr", 144'(Mem_Cmd_Address), 144'(0));
    check("mr_tag", 144'(Mem_Cmd_Tag), 144'(0));
    check("mr_done", 144'(done), 144'(0));
    check("mr_dout_valid", 144'(dout_valid), 144'(0));
    repeat (2) @(negedge Mem_Clk);
    Mem_Rst = 1'b0;
    exp_addr_q.delete(); exp_tag_q.delete(); exp_data_q.delete();
    rd_pct = 100;
    drive_inputs();
    repeat (10) tick();
    check("mr_no_done", 144'(done_cnt), 144'(0));
    check("mr_late_acked", 144'(mem_q.size()), 144'(0));
    check("mr_late_tag_err", 144'(tag_err), 144'(1));
    check("mr_no_beats", 144'(beat_cnt), 144'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
